spi_slave_apb_arbiter: RTL and testbench

//  Shares one APB master port between NUM_REQ transaction-level requesters.

---
 rtl/spi_slave_apb_arbiter.sv | 156 +++++++++++++++
 tb/tb_spi_slave_apb_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_apb_arbiter.sv
// spi_slave_apb_arbiter
//   Shares one APB master port between NUM_REQ transaction-level requesters
//   (for example the SPI-slave APB plug and a debug or DMA bridge). It runs the
//   APB SETUP/ACCESS sequence itself and grants the bus round-robin. A requester
//   can lock the bus across a burst. A transfer that waits too long for PREADY
//   completes with an error response.
//
// Ports
//   apb_pclk_i     single rising-edge clock
//   apb_preset_ni  synchronous active-low reset
//   req_valid_i    per-requester request pending
//   req_lock_i     per-requester "keep the grant after this transfer"
//   req_write_i    per-requester direction, 1 = write
//   req_addr_i     packed addresses, requester i at [i*AW +: AW]
//   req_wdata_i    packed write data, requester i at [i*DW +: DW]
//   req_ready_o    one-hot combinational accept strobe
//   rsp_valid_o    one-hot single-cycle completion pulse
//   rsp_rdata_o    read data, qualified by rsp_valid_o
//   rsp_err_o      timeout flag, qualified by rsp_valid_o
//   apb_*          APB master signals
module spi_slave_apb_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                              apb_pclk_i,
  input  logic                              apb_preset_ni,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  input  logic [NUM_REQ-1:0]                req_lock_i,
  input  logic [NUM_REQ-1:0]                req_write_i,
  input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*APB_DATA_WIDTH-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  output logic [NUM_REQ-1:0]                rsp_valid_o,
  output logic [APB_DATA_WIDTH-1:0]         rsp_rdata_o,
  output logic                              rsp_err_o,
  output logic                              apb_psel_o,
  output logic                              apb_penable_o,
  output logic [APB_ADDR_WIDTH-1:0]         apb_paddr_o,
  output logic                              apb_pwrite_o,
  output logic [APB_DATA_WIDTH-1:0]         apb_pwdata_o,
  input  logic [APB_DATA_WIDTH-1:0]         apb_prdata_i,
  input  logic                              apb_pready_i
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);
  localparam logic [PTR_W:0]   NUM_REQ_EXT = (PTR_W + 1)'(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ - 1){1'b0}}, 1'b1};

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  logic [1:0]         state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   owner;
  logic               lock;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_REQ-1:0] eligible;
  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W:0]     cand_idx;

  assign apb_psel_o    = (state != ST_IDLE);
  assign apb_penable_o = (state == ST_ACCESS);

  // While the bus is locked only the current owner may compete.
  always_comb begin
    eligible = req_valid_i;
    if (lock) eligible = req_valid_i & (ONE_HOT0 << owner);
  end

  // Round-robin search starting at rr_ptr; the extra bit of cand_idx lets the
  // sum of pointer and offset exceed NUM_REQ before wrapping back.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_idx = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
      if (cand_idx >= NUM_REQ_EXT) cand_idx = cand_idx - NUM_REQ_EXT;
      if (!win_found && eligible[cand_idx[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand_idx[PTR_W-1:0];
      end
    end
  end

  // Accept only from IDLE, and never in a reset cycle where the grant would be lost.
  always_comb begin
    req_ready_o = '0;
    if (state == ST_IDLE && win_found && apb_preset_ni) req_ready_o[win_idx] = 1'b1;
  end

  // APB sequencing, arbitration bookkeeping, timeout and the response pulse.
  always_ff @(posedge apb_pclk_i) begin
    if (!apb_preset_ni) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      lock         <= 1'b0;
      cnt          <= '0;
      apb_paddr_o  <= '0;
      apb_pwrite_o <= 1'b0;
      apb_pwdata_o <= '0;
      rsp_valid_o  <= '0;
      rsp_rdata_o  <= '0;
      rsp_err_o    <= 1'b0;
    end else begin
      rsp_valid_o <= '0;
      case (state)
        ST_IDLE: begin
          // An owner that went quiet gives up the lock; nobody is granted this cycle.
          if (lock && !req_valid_i[owner]) begin
            lock <= 1'b0;
          end else if (win_found) begin
            apb_paddr_o  <= req_addr_i[win_idx*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
            apb_pwdata_o <= req_wdata_i[win_idx*APB_DATA_WIDTH +: APB_DATA_WIDTH];
            apb_pwrite_o <= req_write_i[win_idx];
            owner        <= win_idx;
            lock         <= req_lock_i[win_idx];
            rr_ptr       <= (win_idx == PTR_LAST) ? '0 : win_idx + 1'b1;
            state        <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          cnt   <= '0;
          state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // PREADY is tested first so it wins over a simultaneous terminal count.
          if (apb_pready_i) begin
            rsp_rdata_o <= apb_pwrite_o ? '0 : apb_prdata_i;
            rsp_err_o   <= 1'b0;
            rsp_valid_o <= ONE_HOT0 << owner;
            state       <= ST_IDLE;
          end else if (TIMEOUT_CYCLES != 0 && cnt == CNT_LAST) begin
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b1;
            rsp_valid_o <= ONE_HOT0 << owner;
            lock        <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_apb_arbiter.sv
// tb_spi_slave_apb_arbiter
//   Randomized bench for spi_slave_apb_arbiter with three requesters and a
//   four-cycle PREADY timeout. Each transfer is tracked as a timeline:
//   granted in cycle g, SETUP at g+1, ACCESS for a fixed number of cycles
//   after that, response in the following cycle. The APB slave side picks a
//   wait count per transfer, some of which run past the timeout.
module tb_spi_slave_apb_arbiter;

  localparam int NUM_REQ = 3;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TO      = 4;

  logic                 clk = 1'b0;
  logic                 apb_preset_ni;
  logic [NUM_REQ-1:0]   req_valid_i;
  logic [NUM_REQ-1:0]   req_lock_i;
  logic [NUM_REQ-1:0]   req_write_i;
  logic [NUM_REQ*AW-1:0] req_addr_i;
  logic [NUM_REQ*DW-1:0] req_wdata_i;
  logic [NUM_REQ-1:0]   req_ready_o;
  logic [NUM_REQ-1:0]   rsp_valid_o;
  logic [DW-1:0]        rsp_rdata_o;
  logic                 rsp_err_o;
  logic                 apb_psel_o;
  logic                 apb_penable_o;
  logic [AW-1:0]        apb_paddr_o;
  logic                 apb_pwrite_o;
  logic [DW-1:0]        apb_pwdata_o;
  logic [DW-1:0]        apb_prdata_i;
  logic                 apb_pready_i;

  always #5 clk = ~clk;

  spi_slave_apb_arbiter #(
    .NUM_REQ(NUM_REQ),
    .APB_ADDR_WIDTH(AW),
    .APB_DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .apb_pclk_i(clk),
    .apb_preset_ni(apb_preset_ni),
    .req_valid_i(req_valid_i),
    .req_lock_i(req_lock_i),
    .req_write_i(req_write_i),
    .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i),
    .req_ready_o(req_ready_o),
    .rsp_valid_o(rsp_valid_o),
    .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o),
    .apb_psel_o(apb_psel_o),
    .apb_penable_o(apb_penable_o),
    .apb_paddr_o(apb_paddr_o),
    .apb_pwrite_o(apb_pwrite_o),
    .apb_pwdata_o(apb_pwdata_o),
    .apb_prdata_i(apb_prdata_i),
    .apb_pready_i(apb_pready_i)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int req_pct = 0;
  bit rst_req = 1'b0;

  // Requester side: one outstanding request per requester.
  bit            has_req [NUM_REQ];
  logic [AW-1:0] r_addr  [NUM_REQ];
  logic [DW-1:0] r_wdata [NUM_REQ];
  bit            r_write [NUM_REQ];
  bit            r_lock  [NUM_REQ];

  // Reference model: bus ownership plus the timeline of the current transfer.
  bit                 m_busy;
  int                 m_g;
  int                 m_waits;
  int                 m_acc_len;
  int                 m_owner;
  int                 m_ptr;
  bit                 m_lock;
  logic [AW-1:0]      m_paddr;
  bit                 m_pwrite;
  logic [DW-1:0]      m_pwdata;
  logic [NUM_REQ-1:0] m_rsp_valid;
  logic [DW-1:0]      m_rsp_rdata;
  bit                 m_rsp_err;
  int                 winner;
  logic [DW-1:0]      cur_prdata;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got 0x%0h want 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  // Who gets the bus this cycle, or -1 if nobody.
  function automatic int pick_winner(input bit rst_n);
    if (m_busy || !rst_n) return -1;
    if (m_lock) return has_req[m_owner] ? m_owner : -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      int i;
      i = (m_ptr + k) % NUM_REQ;
      if (has_req[i]) return i;
    end
    return -1;
  endfunction

  task automatic reset_model();
    m_busy      = 1'b0;
    m_ptr       = 0;
    m_lock      = 1'b0;
    m_owner     = 0;
    m_paddr     = '0;
    m_pwrite    = 1'b0;
    m_pwdata    = '0;
    m_rsp_valid = '0;
    m_rsp_rdata = '0;
    m_rsp_err   = 1'b0;
  endtask

  // One clock cycle: drive inputs at the falling edge, check, then advance the model.
  task automatic applyStimulus(input bit rst_n, input bit do_check);
    logic [NUM_REQ-1:0] exp_ready;
    @(negedge clk);
    apb_preset_ni = rst_n;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst_n && !has_req[i] && $urandom_range(99) < req_pct) begin
        has_req[i] = 1'b1;
        r_addr[i]  = $urandom;
        r_wdata[i] = $urandom;
        r_write[i] = 1'($urandom_range(1));
        r_lock[i]  = 1'($urandom_range(1));
      end
      req_valid_i[i]          = has_req[i];
      req_lock_i[i]           = r_lock[i];
      req_write_i[i]          = r_write[i];
      req_addr_i[i*AW +: AW]  = r_addr[i];
      req_wdata_i[i*DW +: DW] = r_wdata[i];
    end
    cur_prdata = $urandom;
    apb_prdata_i = cur_prdata;
    if (m_busy && cyc >= m_g + 2) apb_pready_i = ((cyc - (m_g + 2)) == m_waits);
    else apb_pready_i = 1'($urandom_range(1));
    #1;
    winner = pick_winner(rst_n);
    exp_ready = '0;
    if (winner >= 0) exp_ready[winner] = 1'b1;
    if (do_check) begin
      checkOutput("req_ready", 64'(req_ready_o), 64'(exp_ready));
      checkOutput("psel", 64'(apb_psel_o), 64'(m_busy));
      checkOutput("penable", 64'(apb_penable_o), 64'(m_busy && cyc >= m_g + 2));
      checkOutput("paddr", 64'(apb_paddr_o), 64'(m_paddr));
      checkOutput("pwrite", 64'(apb_pwrite_o), 64'(m_pwrite));
      checkOutput("pwdata", 64'(apb_pwdata_o), 64'(m_pwdata));
      checkOutput("rsp_valid", 64'(rsp_valid_o), 64'(m_rsp_valid));
      if (m_rsp_valid != '0) begin
        checkOutput("rsp_rdata", 64'(rsp_rdata_o), 64'(m_rsp_rdata));
        checkOutput("rsp_err", 64'(rsp_err_o), 64'(m_rsp_err));
      end
    end
    @(posedge clk);
    if (!rst_n) begin
      reset_model();
    end else begin
      m_rsp_valid = '0;
      if (m_busy) begin
        if (cyc == m_g + 1 + m_acc_len) begin
          m_busy = 1'b0;
          m_rsp_valid[m_owner] = 1'b1;
          if (m_waits < TO) begin
            m_rsp_err   = 1'b0;
            m_rsp_rdata = m_pwrite ? '0 : cur_prdata;
          end else begin
            m_rsp_err   = 1'b1;
            m_rsp_rdata = '0;
            m_lock      = 1'b0;
          end
        end
      end else if (m_lock && !has_req[m_owner]) begin
        m_lock = 1'b0;
      end else if (winner >= 0) begin
        m_busy     = 1'b1;
        m_g        = cyc;
        m_waits    = $urandom_range(5);
        m_acc_len  = (m_waits < TO) ? m_waits + 1 : TO;
        m_owner    = winner;
        m_ptr      = (winner + 1) % NUM_REQ;
        m_lock     = r_lock[winner];
        m_paddr    = r_addr[winner];
        m_pwrite   = r_write[winner];
        m_pwdata   = r_wdata[winner];
        has_req[winner] = 1'b0;
      end
    end
    cyc++;
  endtask

  initial begin
    apb_preset_ni = 1'b0;
    req_valid_i   = '0;
    req_lock_i    = '0;
    req_write_i   = '0;
    req_addr_i    = '0;
    req_wdata_i   = '0;
    apb_prdata_i  = '0;
    apb_pready_i  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      has_req[i] = 1'b0;
      r_addr[i]  = '0;
      r_wdata[i] = '0;
      r_write[i] = 1'b0;
      r_lock[i]  = 1'b0;
    end
    m_g = 0;
    m_waits = 0;
    m_acc_len = 0;
    reset_model();

    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);

    // Moderate load, then saturated contention, then sparse traffic; a reset
    // is dropped into an ACCESS phase periodically.
    for (int n = 0; n < 3000; n++) begin
      req_pct = (n < 1000) ? 50 : (n < 2000) ? 100 : 25;
      if (n % 250 == 200) rst_req = 1'b1;
      if (rst_req && m_busy && cyc >= m_g + 2) begin
        rst_req = 1'b0;
        applyStimulus(1'b0, 1'b1);
      end else begin
        applyStimulus(1'b1, 1'b1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
